// File: rtl/game_pkg.sv
// Shared definitions for the game score keeper: state encoding,
// default score width and the BCD digit type.
package game_pkg;

  localparam int NUM_DIGITS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/game_score_keeper_bcd_add_sat.sv
// Combinational BCD adder: adds 0..2 to an N-digit packed BCD value with
// ripple carry and clamps to all nines when the top digit overflows.
module bcd_add_sat import game_pkg::*; #(
  parameter int N = NUM_DIGITS_DEF
) (
  input  logic [4*N-1:0] i_value,
  input  logic [1:0]     i_inc,
  output logic [4*N-1:0] o_sum
);

  logic [4*N-1:0] raw_s;
  logic [1:0]     carry_s;
  logic [4:0]     tmp_s;
  bcd_digit_t     digit_s;

  // Ripple the increment through each digit, then saturate on carry-out
  always_comb begin
    raw_s   = {(4*N){1'b0}};
    carry_s = i_inc;
    tmp_s   = 5'd0;
    digit_s = 4'd0;
    for (int i = 0; i < N; i++) begin
      digit_s = i_value[4*i +: 4];
      tmp_s   = {1'b0, digit_s} + {3'b000, carry_s};
      if (tmp_s > 5'd9) begin
        raw_s[4*i +: 4] = 4'(tmp_s - 5'd10);
        carry_s         = 2'd1;
      end else begin
        raw_s[4*i +: 4] = tmp_s[3:0];
        carry_s         = 2'd0;
      end
    end
    if (carry_s != 2'd0) begin
      o_sum = {N{4'h9}};
    end else begin
      o_sum = raw_s;
    end
  end

endmodule

// File: rtl/game_score_keeper.sv
// Game score keeper: collapses per-pixel coin/collision levels into one
// event per source per frame and maintains BCD score, lives and game state.
module game_score_keeper import game_pkg::*; #(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_v_sync,
  input  logic                    i_scored_left,
  input  logic                    i_scored_right,
  input  logic                    i_collision,
  input  logic                    i_start,
  output logic [4*NUM_DIGITS-1:0] o_score_bcd,
  output logic [3:0]              o_lives,
  output logic [1:0]              o_state,
  output logic                    o_invuln,
  output logic                    o_score_pulse,
  output logic                    o_game_over
);

  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] score_q, score_d, score_inc_s;
  logic [3:0]              lives_q, lives_d;
  logic [7:0]              invuln_q, invuln_d;
  logic                    left_f_q, left_f_d;
  logic                    right_f_q, right_f_d;
  logic                    coll_f_q, coll_f_d;
  logic                    score_pulse_q, score_pulse_d;
  logic                    v_sync_dly_q;
  logic                    start_dly_q;
  // Set once i_start has been seen low since reset, so a button held
  // through reset cannot start a game.
  logic                    start_arm_q;

  logic       frame_tick_s, start_edge_s;
  logic       left_ev_s, right_ev_s, coll_ev_s, life_lost_s;
  logic [1:0] inc_s;

  assign frame_tick_s = i_v_sync & ~v_sync_dly_q;
  assign start_edge_s = i_start & ~start_dly_q & start_arm_q;
  assign left_ev_s    = left_f_q | i_scored_left;
  assign right_ev_s   = right_f_q | i_scored_right;
  assign coll_ev_s    = coll_f_q | i_collision;
  assign inc_s        = {1'b0, left_ev_s} + {1'b0, right_ev_s};
  assign life_lost_s  = (state_q == ST_PLAY) & frame_tick_s &
                        (invuln_q == 8'd0) & coll_ev_s;

  bcd_add_sat #(.N(NUM_DIGITS)) u_add (
    .i_value (score_q),
    .i_inc   (inc_s),
    .o_sum   (score_inc_s)
  );

  // State register plus all datapath and edge-detect flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      score_q       <= {(4*NUM_DIGITS){1'b0}};
      lives_q       <= 4'd0;
      invuln_q      <= 8'd0;
      left_f_q      <= 1'b0;
      right_f_q     <= 1'b0;
      coll_f_q      <= 1'b0;
      score_pulse_q <= 1'b0;
      v_sync_dly_q  <= 1'b0;
      start_dly_q   <= 1'b0;
      start_arm_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      invuln_q      <= invuln_d;
      left_f_q      <= left_f_d;
      right_f_q     <= right_f_d;
      coll_f_q      <= coll_f_d;
      score_pulse_q <= score_pulse_d;
      v_sync_dly_q  <= i_v_sync;
      start_dly_q   <= i_start;
      start_arm_q   <= start_arm_q | ~i_start;
    end
  end

  // Next-state logic: start edge enters PLAY, losing the last life ends it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge_s) state_d = ST_PLAY;
        else              state_d = state_q;
      end
      ST_PLAY: begin
        if (life_lost_s && (lives_q == 4'd1)) state_d = ST_OVER;
        else                                  state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Score, lives, invulnerability and sticky-flag updates
  always_comb begin
    score_d       = score_q;
    lives_d       = lives_q;
    invuln_d      = invuln_q;
    left_f_d      = left_f_q;
    right_f_d     = right_f_q;
    coll_f_d      = coll_f_q;
    score_pulse_d = 1'b0;
    if ((state_q != ST_PLAY) && start_edge_s) begin
      score_d   = {(4*NUM_DIGITS){1'b0}};
      lives_d   = 4'(START_LIVES);
      invuln_d  = 8'd0;
      left_f_d  = 1'b0;
      right_f_d = 1'b0;
      coll_f_d  = 1'b0;
    end else if (state_q == ST_PLAY) begin
      if (frame_tick_s) begin
        score_d       = score_inc_s;
        score_pulse_d = (inc_s != 2'd0);
        if (invuln_q != 8'd0) begin
          invuln_d = invuln_q - 8'd1;
        end else if (coll_ev_s) begin
          lives_d  = lives_q - 4'd1;
          invuln_d = 8'(INVULN_FRAMES);
        end else begin
          invuln_d = invuln_q;
        end
        left_f_d  = 1'b0;
        right_f_d = 1'b0;
        coll_f_d  = 1'b0;
      end else begin
        left_f_d  = left_f_q | i_scored_left;
        right_f_d = right_f_q | i_scored_right;
        coll_f_d  = coll_f_q | i_collision;
      end
    end else begin
      left_f_d  = 1'b0;
      right_f_d = 1'b0;
      coll_f_d  = 1'b0;
    end
  end

  // Outputs come straight from registers
  always_comb begin
    o_score_bcd   = score_q;
    o_lives       = lives_q;
    o_state       = state_q;
    o_invuln      = (invuln_q != 8'd0);
    o_score_pulse = score_pulse_q;
    o_game_over   = (state_q == ST_OVER);
  end

endmodule

// File: tb/tb_game_score_keeper.sv
// Self-checking bench for game_score_keeper: directed scenarios plus random
// frames, compared every cycle against an integer-level game model.
module tb_game_score_keeper;

  localparam int START_LIVES = 3;
  localparam int INVULN      = 60;
  localparam int MAX_SCORE   = 9999;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v_sync = 1'b0, sl = 1'b0, sr = 1'b0, coll = 1'b0, start = 1'b1;
  logic [15:0] o_score_bcd;
  logic [3:0]  o_lives;
  logic [1:0]  o_state;
  logic        o_invuln, o_score_pulse, o_game_over;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;

  game_score_keeper #(.NUM_DIGITS(4), .START_LIVES(START_LIVES), .INVULN_FRAMES(INVULN)) dut (
    .i_clk(clk), .i_rst(rst), .i_v_sync(v_sync),
    .i_scored_left(sl), .i_scored_right(sr), .i_collision(coll), .i_start(start),
    .o_score_bcd(o_score_bcd), .o_lives(o_lives), .o_state(o_state),
    .o_invuln(o_invuln), .o_score_pulse(o_score_pulse), .o_game_over(o_game_over)
  );

  always #5 clk = ~clk;

  // Game model: plain integers, 0=IDLE 1=PLAY 2=GAME_OVER
  typedef struct {
    int score; int lives; int st; int inv;
    bit lf; bit rf; bit cf; bit vprev; bit sprev; bit pulse;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.score = 0; r.lives = 0; r.st = 0; r.inv = 0;
    r.lf = 0; r.rf = 0; r.cf = 0; r.vprev = 0; r.pulse = 0;
    r.sprev = 1;  // a start held through reset must first be released
    return r;
  endfunction

  function automatic model_t model_step(model_t c, bit vs, bit l, bit r, bit k, bit st);
    model_t n;
    bit tick, sedge;
    int d;
    n = c;
    tick  = vs && !c.vprev;
    sedge = st && !c.sprev;
    n.vprev = vs; n.sprev = st; n.pulse = 0;
    if (sedge && c.st != 1) begin
      n.st = 1; n.score = 0; n.lives = START_LIVES; n.inv = 0;
      n.lf = 0; n.rf = 0; n.cf = 0;
    end else if (c.st == 1) begin
      if (tick) begin
        d = int'(c.lf || l) + int'(c.rf || r);
        n.score = (c.score + d > MAX_SCORE) ? MAX_SCORE : c.score + d;
        n.pulse = (d > 0);
        if (c.inv > 0) n.inv = c.inv - 1;
        else if (c.cf || k) begin
          n.lives = c.lives - 1;
          n.inv = INVULN;
          if (n.lives == 0) n.st = 2;
        end
        n.lf = 0; n.rf = 0; n.cf = 0;
      end else begin
        n.lf = c.lf || l; n.rf = c.rf || r; n.cf = c.cf || k;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] b;
    b = 16'h0;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  // Model advances on the same edges as the design
  always @(posedge clk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, v_sync, sl, sr, coll, start);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("score", 32'(o_score_bcd), 32'(to_bcd(m.score)));
    chk("lives", 32'(o_lives), 32'(m.lives));
    chk("state", 32'(o_state), 32'(m.st));
    chk("invuln", 32'(o_invuln), 32'(m.inv > 0));
    chk("pulse", 32'(o_score_pulse), 32'(m.pulse));
    chk("game_over", 32'(o_game_over), 32'(m.st == 2));
    if (o_score_pulse) pulse_cnt++;
  endtask

  task automatic step(input bit vs, input bit l, input bit r, input bit k, input bit st);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    v_sync = vs; sl = l; sr = r; coll = k; start = st;
  endtask

  // Let the pending frame commit, then sample the result
  task automatic settle(input bit st);
    step(1'b0, 1'b0, 1'b0, 1'b0, st);
    @(negedge clk);
    compare_all();
  endtask

  task automatic frame(input int len, input bit l, input bit r, input bit k);
    for (int i = 0; i < len - 1; i++) step(1'b0, l, r, k, start);
    step(1'b1, l, r, k, start);
  endtask

  task automatic apply_reset(input bit st);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1; start = st;
    #1;
    compare_all();
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, st);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int pc0;
    bit st_r;
    // Reset with start held
    #12;
    compare_all();
    chk("rst_score", 32'(o_score_bcd), 32'h0);
    chk("rst_state", 32'(o_state), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("held_start_idle", 32'(o_state), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle(1'b1);
    chk("start_state", 32'(o_state), 32'd1);
    chk("start_lives", 32'(o_lives), 32'd3);

    // Single coin held for 500 cycles
    pc0 = pulse_cnt;
    repeat (500) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    settle(1'b1);
    chk("single_coin", 32'(o_score_bcd), 32'h0001);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("single_pulse_count", 32'(pulse_cnt - pc0), 32'd1);

    // Both coins, carry through 0099
    repeat (49) frame(2, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("score_99", 32'(o_score_bcd), 32'h0099);
    frame(2, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("score_101", 32'(o_score_bcd), 32'h0101);

    // Invulnerability window
    frame(3, 1'b0, 1'b0, 1'b1);
    settle(1'b1);
    chk("hit1_lives", 32'(o_lives), 32'd2);
    chk("hit1_invuln", 32'(o_invuln), 32'd1);
    repeat (60) frame(3, 1'b0, 1'b0, 1'b1);
    settle(1'b1);
    chk("invuln_lives", 32'(o_lives), 32'd2);
    frame(3, 1'b0, 1'b0, 1'b1);
    settle(1'b1);
    chk("hit62_lives", 32'(o_lives), 32'd1);

    // Game over with a coin in the same frame, then frozen
    repeat (60) frame(3, 1'b0, 1'b0, 1'b0);
    settle(1'b1);
    chk("invuln_expired", 32'(o_invuln), 32'd0);
    frame(3, 1'b1, 1'b0, 1'b1);
    settle(1'b1);
    chk("over_score", 32'(o_score_bcd), 32'h0102);
    chk("over_lives", 32'(o_lives), 32'd0);
    chk("over_state", 32'(o_state), 32'd2);
    chk("over_flag", 32'(o_game_over), 32'd1);
    repeat (3) frame(3, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("over_frozen", 32'(o_score_bcd), 32'h0102);

    // Restart on a start edge that coincides with a frame tick
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    settle(1'b1);
    chk("restart_score", 32'(o_score_bcd), 32'h0);
    chk("restart_lives", 32'(o_lives), 32'd3);
    chk("restart_state", 32'(o_state), 32'd1);

    // Saturation at 9999
    repeat (4999) frame(2, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("score_9998", 32'(o_score_bcd), 32'h9998);
    frame(2, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("sat_9999", 32'(o_score_bcd), 32'h9999);
    frame(2, 1'b1, 1'b1, 1'b0);
    settle(1'b1);
    chk("sat_hold", 32'(o_score_bcd), 32'h9999);

    // Reset mid-frame with flags set and start held
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_score", 32'(o_score_bcd), 32'h0);
    chk("mid_rst_lives", 32'(o_lives), 32'd0);
    chk("mid_rst_state", 32'(o_state), 32'd0);
    chk("mid_rst_pulse", 32'(o_score_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_held_idle", 32'(o_state), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(3, 1'b0, 1'b0, 1'b0);
    settle(1'b1);
    chk("flags_dropped", 32'(o_score_bcd), 32'h0);

    // Random frames against the model
    st_r = 1'b1;
    for (int f = 0; f < 400; f++) begin
      int lo, hi;
      lo = int'($urandom_range(1, 10));
      hi = int'($urandom_range(1, 4));
      for (int c = 0; c < lo + hi; c++) begin
        if ($urandom % 20 == 0) st_r = ~st_r;
        step(c >= lo, $urandom % 4 == 0, $urandom % 4 == 0, $urandom % 6 == 0, st_r);
      end
      if ($urandom % 100 == 0) apply_reset(st_r);
    end
    settle(st_r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/game_score_keeper.md
# game_score_keeper

Consumes the per-pixel `o_scored` and `o_sprite_hit` levels from the lane coin and obstacle sprite renderers, plus the frame sync. Collapses them into at most one event per source per frame, and maintains the game's BCD score, remaining lives and the IDLE/PLAY/GAME_OVER state. Sits between the sprite layer and the HUD/text renderer; its outputs are stable for a whole frame except at the frame-commit edge.

## Interface
- `NUM_DIGITS`, 4: BCD score digits; the score saturates at all nines.
- `START_LIVES`, 3: lives loaded on game start (1..15).
- `INVULN_FRAMES`, 60: frames after a life loss during which collisions are ignored (1..255).
- `i_clk`  in  1  pixel clock; all logic on its rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_v_sync`  in  1  frame sync level, same clock domain; its rising edge is the frame boundary.
- `i_scored_left`  in  1  left coin scored level; may be high for any number of cycles.
- `i_scored_right`  in  1  right coin scored level; same rules as the left input.
- `i_collision`  in  1  penguin/obstacle overlap level, pixel-granular.
- `i_start`  in  1  start button level, already debounced.
- `o_score_bcd`  out  4*NUM_DIGITS  score, packed BCD, digit 0 in the LSBs.
- `o_lives`  out  4  lives remaining.
- `o_state`  out  2  0 = IDLE, 1 = PLAY, 2 = GAME_OVER.
- `o_invuln`  out  1  high while the invulnerability counter is nonzero.
- `o_score_pulse`  out  1  one-cycle pulse on any frame where the score increased.
- `o_game_over`  out  1  equals (`o_state` == GAME_OVER).

## Operation
**Reset values**
- score = 0, lives = 0, state = IDLE, invulnerability counter = 0.
- `o_score_pulse` = 0; all sticky flags = 0; sync-delay register = 0.

**Frame tick and sticky flags**
- `frame_tick` = `i_v_sync` & ~`v_sync_d`, where `v_sync_d` is a one-cycle register of `i_v_sync`.
- Sticky flags `left_f`, `right_f`, `coll_f` set whenever their input is high.
- On a `frame_tick` cycle, the effective event is `flag | input`, and all flags clear on that edge.
- Inputs outside PLAY are ignored and the flags are held at 0.

**State machine**
- IDLE: a rising edge of `i_start` moves to PLAY; score := 0, lives := `START_LIVES`, invuln := 0, flags := 0.
- PLAY: on each `frame_tick`:
  - Score increment d = `left_ev` + `right_ev` (0..2). It is added in BCD with carry, then saturated to all nines.
  - If d > 0, pulse `o_score_pulse` on the following cycle.
  - If invuln > 0, decrement it and ignore `coll_ev`.
  - Otherwise, if `coll_ev` is set: lives := lives−1 and invuln := `INVULN_FRAMES`.
  - If that decrement makes lives 0, go to GAME_OVER on the same edge. Any score from that frame still commits.
- GAME_OVER: score and lives freeze. A rising edge of `i_start` restarts exactly as from IDLE.
- A start edge coinciding with `frame_tick` in GAME_OVER takes the start; the frame events are discarded.
- `i_start` edge detection uses its own delay register, reset to 0. A button held through reset does not start a game.

## Timing
- Score, lives and state change only on the clock edge where `frame_tick` = 1, or on the start edge.
- Registered outputs are visible the cycle after that edge.
- `o_score_pulse` is high exactly one cycle: the cycle after the commit edge.
- Latency from the `i_v_sync` rising edge to updated outputs: 1 cycle.
- Multiple high cycles of the same input within one frame count once. Both coins in one frame count +2.
- An asynchronous reset mid-frame returns to IDLE immediately and drops pending flags.
- `i_v_sync` held high for many cycles produces a single tick.

## Structure
- Shared package (`game_pkg`):
  - state encoding constants (IDLE/PLAY/GAME_OVER);
  - `NUM_DIGITS` default;
  - BCD digit typedef.
- Sub-module `bcd_add_sat`: combinational, adds 0..2 to an N-digit packed BCD value with ripple carry and saturation to all nines.
- Everything else is one file: edge detectors, flags, FSM, invulnerability counter.

## Test plan
- **Single coin:** start, then hold `i_scored_left` high for 500 cycles within frame 1.
  - Required: after the tick, score = 0x0001; one `o_score_pulse`.
- **Both coins and carry:** preload score to 0x0099, then assert both coins in one frame.
  - Required: 0x0101 after the tick. Starting from 0x9998, the score saturates to 0x9999.
- **Invulnerability:** collide in frame 1, lives 3→2, `o_invuln` = 1; collide again in frames 2..60.
  - Required: lives stay 2. A collision in frame 62 takes lives to 1.
- **Game over and restart:** with lives = 1, collide; also assert a coin in the same frame.
  - Required: score increments, lives = 0, state = GAME_OVER; further coins ignored.
  - Then an `i_start` edge restarts: score 0, lives 3, state PLAY.
- **Reset and held inputs:** apply `i_rst` while flags are set.
  - Required: all outputs go to their reset values immediately.
  - `i_start` held high through reset release gives no start until it falls and rises again.
